// File: rtl/e_mdu_if.sv
// E-stage multiply/divide unit bus: pipeline-side controls, operands and
// the busy/stall/result outputs.
interface e_mdu_if;
    logic        Req;
    logic        E_MDU_start;
    logic [3:0]  E_MDUop;
    logic        E_MDUout_sel;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_MDU_busy;
    logic        E_MDU_stall;
    logic [31:0] E_MDU_out;

    modport master (
        output Req, E_MDU_start, E_MDUop, E_MDUout_sel, E_A, E_B,
        input  E_MDU_busy, E_MDU_stall, E_MDU_out
    );

    modport slave (
        input  Req, E_MDU_start, E_MDUop, E_MDUout_sel, E_A, E_B,
        output E_MDU_busy, E_MDU_stall, E_MDU_out
    );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers. Multi-cycle ops hold
// latched operands and commit to HI/LO on the edge where busy falls.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        signed_q, signed_d;

    logic        busy;
    logic        op_valid;
    logic        op_long;
    logic        accept;

    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign busy     = (state_q != StIdle);
    assign op_valid = (bus.E_MDUop >= 4'd1) && (bus.E_MDUop <= 4'd6);
    assign op_long  = (bus.E_MDUop >= 4'd1) && (bus.E_MDUop <= 4'd4);
    // A cancelled (Req) or overlapping start never reaches the datapath.
    assign accept   = bus.E_MDU_start & ~bus.Req & ~busy & op_valid;

    assign prod = signed_q ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                           : ({32'b0, a_q} * {32'b0, b_q});

    // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_mag = (signed_q & a_q[31]) ? -a_q : a_q;
    assign b_mag = (signed_q & b_q[31]) ? -b_q : b_q;
    assign q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    assign r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    assign quot  = (signed_q & (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    assign rem   = (signed_q & a_q[31]) ? -r_mag : r_mag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.E_MDUop)
                        4'd1, 4'd2: begin
                            state_d  = StMult;
                            cnt_d    = 32'(MULT_CYCLES);
                            a_d      = bus.E_A;
                            b_d      = bus.E_B;
                            signed_d = (bus.E_MDUop == 4'd1);
                        end
                        4'd3, 4'd4: begin
                            state_d  = StDiv;
                            cnt_d    = 32'(DIV_CYCLES);
                            a_d      = bus.E_A;
                            b_d      = bus.E_B;
                            signed_d = (bus.E_MDUop == 4'd3);
                        end
                        4'd5:    hi_d = bus.E_A;
                        4'd6:    lo_d = bus.E_A;
                        default: ;
                    endcase
                end
            end
            StMult, StDiv: begin
                if (cnt_q <= 32'd1) begin
                    state_d = StIdle;
                    cnt_d   = 32'd0;
                    if (state_q == StMult) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
        end
    end

    assign bus.E_MDU_busy  = busy;
    assign bus.E_MDU_stall = busy | (bus.E_MDU_start & op_long);
    assign bus.E_MDU_out   = bus.E_MDUout_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: each task drives one scenario and checks
// busy/stall/HI/LO against hand-computed values.
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Req = 1'b0;
        bus.E_MDU_start = 1'b0;
        bus.E_MDUop = 4'd0;
        bus.E_MDUout_sel = 1'b0;
        bus.E_A = 32'd0;
        bus.E_B = 32'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.E_MDU_start = 1'b1;
        bus.E_MDUop = op;
        bus.E_A = a;
        bus.E_B = b;
        #1;
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        bus.E_MDUout_sel = 1'b1;
        #1 hi = bus.E_MDU_out;
        bus.E_MDUout_sel = 1'b0;
        #1 lo = bus.E_MDU_out;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        reset = 1'b0;
        idle_inputs();
        tick();
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_busy: got %b want 0", bus.E_MDU_busy); end
        n_cmp++; if (bus.E_MDU_stall !== 1'b0) begin n_fail++;
            $display("FAIL rst_stall: got %b want 0", bus.E_MDU_stall); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++;
            $display("FAIL rst_hilo: got %h/%h want 0/0", hi, lo); end
        // Ops offered while reset is held must be ignored.
        issue(4'd6, 32'h0000_0055, 32'h0);
        tick();
        issue(4'd1, 32'h0000_0002, 32'h3);
        tick();
        idle_inputs();
        read_hl(hi, lo);
        n_cmp++; if (lo !== 32'h0 || bus.E_MDU_busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_noaccept: got lo=%h busy=%b want 0/0", lo, bus.E_MDU_busy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        logic [31:0] hi, lo;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        n_cmp++; if (bus.E_MDU_stall !== 1'b1) begin n_fail++;
            $display("FAIL mult_stall_accept: got %b want 1", bus.E_MDU_stall); end
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            read_hl(hi, lo);
            n_cmp++; if (bus.E_MDU_busy !== 1'b1 || bus.E_MDU_stall !== 1'b1) begin n_fail++;
                $display("FAIL mult_busy[%0d]: got busy=%b stall=%b want 1/1", i,
                         bus.E_MDU_busy, bus.E_MDU_stall); end
            n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++;
                $display("FAIL mult_hold[%0d]: got %h/%h want 0/0", i, hi, lo); end
            tick();
        end
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || bus.E_MDU_stall !== 1'b0) begin n_fail++;
            $display("FAIL mult_done: got busy=%b stall=%b want 0/0", bus.E_MDU_busy,
                     bus.E_MDU_stall); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin n_fail++;
            $display("FAIL mult_result: got %h/%h want ffffffff/fffffffa", hi, lo); end

        issue(4'd2, 32'hFFFF_FFFE, 32'd3);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            read_hl(hi, lo);
            n_cmp++; if (bus.E_MDU_busy !== 1'b1 || hi !== 32'hFFFF_FFFF) begin n_fail++;
                $display("FAIL multu_busy[%0d]: got busy=%b hi=%h want 1/ffffffff", i,
                         bus.E_MDU_busy, hi); end
            tick();
        end
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || hi !== 32'h2 || lo !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL multu_result: got busy=%b %h/%h want 0 00000002/fffffffa",
                     bus.E_MDU_busy, hi, lo); end
    endtask

    task automatic test_div();
        logic [31:0] hi, lo;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (bus.E_MDU_stall !== 1'b1) begin n_fail++;
            $display("FAIL div_stall_accept: got %b want 1", bus.E_MDU_stall); end
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            read_hl(hi, lo);
            n_cmp++; if (bus.E_MDU_busy !== 1'b1 || lo !== 32'hFFFF_FFFA) begin n_fail++;
                $display("FAIL div_busy[%0d]: got busy=%b lo=%h want 1/fffffffa", i,
                         bus.E_MDU_busy, lo); end
            tick();
        end
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
        begin n_fail++;
            $display("FAIL div_result: got busy=%b %h/%h want 0 ffffffff/fffffffd",
                     bus.E_MDU_busy, hi, lo); end

        issue(4'd4, 32'd7, 32'd0);
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (bus.E_MDU_busy !== 1'b1) begin n_fail++;
                $display("FAIL divu0_busy[%0d]: got %b want 1", i, bus.E_MDU_busy); end
            tick();
        end
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
        begin n_fail++;
            $display("FAIL divu0_unchanged: got busy=%b %h/%h want 0 ffffffff/fffffffd",
                     bus.E_MDU_busy, hi, lo); end

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        idle_inputs();
        repeat (10) tick();
        read_hl(hi, lo);
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h8000_0000) begin n_fail++;
            $display("FAIL div_ovf: got %h/%h want 00000000/80000000", hi, lo); end

        issue(4'd4, 32'd100, 32'd7);
        tick();
        idle_inputs();
        repeat (10) tick();
        read_hl(hi, lo);
        n_cmp++; if (hi !== 32'd2 || lo !== 32'd14) begin n_fail++;
            $display("FAIL divu_result: got %h/%h want 00000002/0000000e", hi, lo); end
    endtask

    task automatic test_move();
        logic [31:0] hi, lo;
        issue(4'd6, 32'h1234_5678, 32'h0);
        n_cmp++; if (bus.E_MDU_stall !== 1'b0) begin n_fail++;
            $display("FAIL mtlo_stall: got %b want 0", bus.E_MDU_stall); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.E_MDU_out !== 32'h1234_5678 || bus.E_MDU_busy !== 1'b0) begin n_fail++;
            $display("FAIL mtlo: got out=%h busy=%b want 12345678/0", bus.E_MDU_out,
                     bus.E_MDU_busy); end
        bus.Req = 1'b1;
        issue(4'd6, 32'hDEAD_BEEF, 32'h0);
        tick();
        idle_inputs();
        issue(4'd5, 32'hCAFE_F00D, 32'h0);
        tick();
        idle_inputs();
        read_hl(hi, lo);
        n_cmp++; if (lo !== 32'h1234_5678) begin n_fail++;
            $display("FAIL mtlo_req: got lo=%h want 12345678", lo); end
        n_cmp++; if (hi !== 32'hCAFE_F00D) begin n_fail++;
            $display("FAIL mthi: got hi=%h want cafef00d", hi); end
        bus.Req = 1'b1;
        issue(4'd5, 32'h1111_1111, 32'h0);
        tick();
        idle_inputs();
        issue(4'd0, 32'h2222_2222, 32'd3);
        n_cmp++; if (bus.E_MDU_stall !== 1'b0) begin n_fail++;
            $display("FAIL none_stall: got %b want 0", bus.E_MDU_stall); end
        tick();
        issue(4'd7, 32'h3333_3333, 32'd3);
        tick();
        idle_inputs();
        read_hl(hi, lo);
        n_cmp++; if (hi !== 32'hCAFE_F00D || lo !== 32'h1234_5678 || bus.E_MDU_busy !== 1'b0)
        begin n_fail++;
            $display("FAIL mthi_req_none: got %h/%h busy=%b want cafef00d/12345678 0",
                     hi, lo, bus.E_MDU_busy); end
    endtask

    task automatic test_req_inflight();
        logic [31:0] hi, lo;
        issue(4'd3, 32'hFFFF_FF9C, 32'd7);
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) bus.Req = 1'b1;
            if (i == 3) begin
                bus.Req = 1'b0;
                issue(4'd3, 32'd50, 32'd5);
                n_cmp++; if (bus.E_MDU_stall !== 1'b1) begin n_fail++;
                    $display("FAIL inflight_stall: got %b want 1", bus.E_MDU_stall); end
            end
            if (i == 4) idle_inputs();
            n_cmp++; if (bus.E_MDU_busy !== 1'b1) begin n_fail++;
                $display("FAIL inflight_busy[%0d]: got %b want 1", i, bus.E_MDU_busy); end
            tick();
        end
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2)
        begin n_fail++;
            $display("FAIL inflight_result: got busy=%b %h/%h want 0 fffffffe/fffffff2",
                     bus.E_MDU_busy, hi, lo); end
        tick();
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || lo !== 32'hFFFF_FFF2) begin n_fail++;
            $display("FAIL inflight_norestart: got busy=%b lo=%h want 0/fffffff2",
                     bus.E_MDU_busy, lo); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo;
        issue(4'd1, 32'd3, 32'd5);
        tick();
        idle_inputs();
        tick();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.E_MDU_busy !== 1'b0) begin n_fail++;
            $display("FAIL midrst_busy: got %b want 0", bus.E_MDU_busy); end
        read_hl(hi, lo);
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++;
            $display("FAIL midrst_hilo: got %h/%h want 0/0", hi, lo); end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (bus.E_MDU_busy !== 1'b0) begin n_fail++;
                $display("FAIL midrst_idle[%0d]: got %b want 0", i, bus.E_MDU_busy); end
        end
        read_hl(hi, lo);
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++;
            $display("FAIL midrst_nocommit: got %h/%h want 0/0", hi, lo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo;
        issue(4'd1, 32'd7, 32'd6);
        tick();
        idle_inputs();
        repeat (5) tick();
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd42) begin n_fail++;
            $display("FAIL b2b_first: got busy=%b %h/%h want 0 0/0000002a", bus.E_MDU_busy,
                     hi, lo); end
        issue(4'd2, 32'h0001_0000, 32'h0001_0000);
        tick();
        idle_inputs();
        n_cmp++; if (bus.E_MDU_busy !== 1'b1) begin n_fail++;
            $display("FAIL b2b_accept: got %b want 1", bus.E_MDU_busy); end
        repeat (5) tick();
        read_hl(hi, lo);
        n_cmp++; if (bus.E_MDU_busy !== 1'b0 || hi !== 32'h1 || lo !== 32'h0) begin n_fail++;
            $display("FAIL b2b_second: got busy=%b %h/%h want 0 00000001/0", bus.E_MDU_busy,
                     hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_req_inflight();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
